// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures period and high time of an external PWM line and reports duty in STEPS steps
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   pwm_in     asynchronous PWM line (synchronised internally)
//   duty_out   floor(H*STEPS/P), 0..STEPS; STEPS or 0 when the line is static high/low
//   period_out last measured period P in clk cycles, 0 when static
//   valid_out  1-cycle pulse when duty_out/period_out update
//   stuck_out  level, set after TIMEOUT cycles without a rising edge, cleared by the next rise
//   missed_out 1-cycle pulse when a measurement is dropped because the divider is busy
// Define PWM_DECODER_GLITCH_FILTER_EN to insert a 3-tap majority filter ahead of edge detection.
module pwm_duty_decoder #(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 255,
  parameter int STEPS = 10,
  localparam int DUTY_W = $clog2(STEPS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pwm_in,
  output logic [DUTY_W-1:0]  duty_out,
  output logic [COUNT_W-1:0] period_out,
  output logic               valid_out,
  output logic               stuck_out,
  output logic               missed_out
);
  localparam int REM_W = COUNT_W + 4;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] TO = COUNT_W'(TIMEOUT);
  localparam logic [DUTY_W-1:0] STEPS_D = DUTY_W'(STEPS);
  typedef enum logic [1:0] {ARM, IDLE, DIV} state_t;
  state_t state;
  logic s1, s2, sig, sig_d, rise, timeout;
  logic [COUNT_W-1:0] period_cnt, high_cnt, p;
  logic [REM_W-1:0] rem;
  logic [DUTY_W-1:0] q;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic h1, h2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h1 <= 1'b0;
      h2 <= 1'b0;
    end else begin
      h1 <= s2;
      h2 <= h1;
    end
  // majority of the last three samples swallows any single-cycle pulse
  assign sig = (s2 & h1) | (s2 & h2) | (h1 & h2);
`else
  assign sig = s2;
`endif
  assign rise = sig & ~sig_d;
  assign timeout = period_cnt >= TO;
  // counters free-run in every state; a rise restarts them with the edge cycle already counted high
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sig_d <= 1'b0;
      period_cnt <= '0;
      high_cnt <= '0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
      sig_d <= sig;
      period_cnt <= rise ? COUNT_W'(1) : (period_cnt == CNT_MAX) ? period_cnt : period_cnt + 1'b1;
      high_cnt <= rise ? COUNT_W'(1) : (high_cnt == CNT_MAX || !sig) ? high_cnt : high_cnt + 1'b1;
    end
  // restoring division by repeated subtraction: one quotient step per cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ARM;
      p <= '0;
      rem <= '0;
      q <= '0;
      duty_out <= '0;
      period_out <= '0;
      valid_out <= 1'b0;
      stuck_out <= 1'b0;
      missed_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      missed_out <= (state == DIV) && rise;
      case (state)
        ARM:
          if (rise) begin
            stuck_out <= 1'b0;
            state <= IDLE;
          end else if (timeout && !stuck_out) begin
            stuck_out <= 1'b1;
            duty_out <= sig ? STEPS_D : '0;
            period_out <= '0;
            valid_out <= 1'b1;
          end
        IDLE:
          if (rise && period_cnt != '0) begin
            p <= period_cnt;
            rem <= REM_W'(high_cnt) * REM_W'(STEPS);
            q <= '0;
            state <= DIV;
          end else if (timeout) begin
            stuck_out <= 1'b1;
            duty_out <= sig ? STEPS_D : '0;
            period_out <= '0;
            valid_out <= 1'b1;
            state <= ARM;
          end
        DIV:
          if (rem >= REM_W'(p)) begin
            rem <= rem - REM_W'(p);
            q <= (q == STEPS_D) ? q : q + 1'b1;
          end else begin
            duty_out <= q;
            period_out <= p;
            valid_out <= 1'b1;
            state <= IDLE;
          end
        default: state <= ARM;
      endcase
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed vectors and corner sequences for pwm_duty_decoder
module tb_pwm_duty_decoder;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int FILT = 1;
  localparam int GL_DUTY = 5;
  localparam int GL_PERIOD = 20;
`else
  localparam int FILT = 0;
  localparam int GL_DUTY = 8;
  localparam int GL_PERIOD = 6;
`endif
  typedef struct {
    int p;
    int h;
    int duty;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n;
  logic pwm_in;
  logic [3:0] duty_out;
  logic [7:0] period_out;
  logic valid_out, stuck_out, missed_out;
  int n_cmp, n_fail, cyc, vcnt, mcnt, vcyc, last_duty, last_period, rise_cyc, v0, m0;
  vec_t vecs[9];
  pwm_duty_decoder dut (
    .clk(clk),
    .reset_n(reset_n),
    .pwm_in(pwm_in),
    .duty_out(duty_out),
    .period_out(period_out),
    .valid_out(valid_out),
    .stuck_out(stuck_out),
    .missed_out(missed_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (valid_out) begin
      vcnt <= vcnt + 1;
      last_duty <= int'(duty_out);
      last_period <= int'(period_out);
      vcyc <= cyc;
    end
    if (missed_out) mcnt <= mcnt + 1;
  end
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      rise_cyc = cyc;
      for (int i = 0; i < p; i++) begin
        pwm_in = (i < h);
        @(negedge clk);
      end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    vecs[0] = '{10, 5, 5};
    vecs[1] = '{40, 13, 3};
    vecs[2] = '{8, 2, 2};
    vecs[3] = '{25, 23, 9};
    vecs[4] = '{100, 33, 3};
    vecs[5] = '{200, 198, 9};
    vecs[6] = '{16, 4, 2};
    vecs[7] = '{12, 10, 8};
    vecs[8] = '{50, 2, 0};
    reset_n = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset duty", int'(duty_out), 0);
    check("reset period", int'(period_out), 0);
    check("reset valid", int'(valid_out), 0);
    check("reset stuck", int'(stuck_out), 0);
    check("reset missed", int'(missed_out), 0);
    reset_n = 1'b1;
    @(negedge clk);
    foreach (vecs[j]) begin
      #1;
      v0 = vcnt;
      m0 = mcnt;
      run(vecs[j].p, vecs[j].h, 4);
      #1;
      check($sformatf("vec%0d duty", j), last_duty, vecs[j].duty);
      check($sformatf("vec%0d period", j), last_period, vecs[j].p);
      check($sformatf("vec%0d valid seen", j), int'(vcnt > v0), 1);
      check($sformatf("vec%0d stuck", j), int'(stuck_out), 0);
      check($sformatf("vec%0d missed", j), mcnt - m0, 0);
    end
    // divider busy: every other edge dropped
    pwm_in = 1'b0;
    repeat (20) @(negedge clk);
    run(6, 3, 2);
    #1;
    v0 = vcnt;
    m0 = mcnt;
    run(6, 3, 8);
    #1;
    check("busy valid count", vcnt - v0, 4);
    check("busy missed count", mcnt - m0, 4);
    check("busy duty", last_duty, 5);
    check("busy period", last_period, 6);
    // reset in the middle of a division
    pwm_in = 1'b0;
    repeat (10) @(negedge clk);
    run(20, 18, 1);
    #1;
    check("pre-reset period nonzero", int'(period_out != 0), 1);
    v0 = vcnt;
    for (int i = 0; i < 20; i++) begin
      pwm_in = (i < 18);
      if (i == 6) begin
        reset_n = 1'b0;
        #1;
        check("mid-div reset duty", int'(duty_out), 0);
        check("mid-div reset period", int'(period_out), 0);
        check("mid-div reset valid", int'(valid_out), 0);
        check("mid-div reset stuck", int'(stuck_out), 0);
        check("mid-div reset missed", int'(missed_out), 0);
      end
      if (i == 9) reset_n = 1'b1;
      @(negedge clk);
    end
    #1;
    check("no valid after reset", vcnt - v0, 0);
    run(20, 18, 2);
    #1;
    check("post-reset valid count", vcnt - v0, 2);
    check("post-reset duty", last_duty, 9);
    check("post-reset period", last_period, 20);
    // static high line
    run(10, 5, 3);
    pwm_in = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    v0 = vcnt;
    check("stuck early", int'(stuck_out), 0);
    repeat (280) @(negedge clk);
    #1;
    check("stuck set", int'(stuck_out), 1);
    check("stuck single valid", vcnt - v0, 1);
    check("stuck duty", last_duty, 10);
    check("stuck period", last_period, 0);
    pwm_in = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("stuck holds through fall", int'(stuck_out), 1);
    v0 = vcnt;
    run(10, 2, 1);
    #1;
    check("stuck cleared by rise", int'(stuck_out), 0);
    check("re-arm no valid", vcnt - v0, 0);
    run(10, 2, 1);
    #1;
    check("resume valid count", vcnt - v0, 1);
    check("resume duty", last_duty, 2);
    check("resume period", last_period, 10);
    // one-cycle low glitch inside the high phase
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 20; i++) begin
        pwm_in = (i < 10) && (i != 5);
        @(negedge clk);
      end
    #1;
    check("glitch duty", last_duty, GL_DUTY);
    check("glitch period", last_period, GL_PERIOD);
    // capture-to-valid latency for q=3
    run(40, 13, 2);
    run(40, 13, 1);
    #1;
    check("latency", vcyc - rise_cyc, 7 + FILT);
    check("latency duty", last_duty, 3);
    check("latency period", last_period, 40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
